memory_game_core_np: RTL and testbench
======================================

MEMORY_GAME_CORE_NP -- requirements
Module: memory_game_core_np

Interface
REQ-001 Parameter NUM_CARDS, 16, board size; even, 4..64.
REQ-002 Parameter NUM_PLAYERS, 2, player count; 2..4.
REQ-003 Parameter TICKS_PER_TURN, 750000000, turn-timer length in clk cycles; >=2.
REQ-004 Parameter REVEAL_TICKS, 50000000, cycles both picked cards stay face-up; >=1.
REQ-005 Derived: IDX_W=clog2(NUM_CARDS), SYM_W=clog2(NUM_CARDS/2) (min 1), PW=clog2(NUM_PLAYERS), CNT_W=clog2(NUM_CARDS/2+1), TW=clog2(TICKS_PER_TURN).
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start_i  in  1  one-cycle start/restart pulse.
REQ-009 click_i  in  1  one-cycle card-select pulse.
REQ-010 sel_idx_i  in  IDX_W  card index sampled with click_i.
REQ-011 layout_i  in  NUM_CARDS*SYM_W  packed symbol per card, card k at [k*SYM_W +: SYM_W]; static during play.
REQ-012 faceup_o  out  NUM_CARDS  face-up mask.
REQ-013 removed_o  out  NUM_CARDS  matched/removed mask.
REQ-014 current_player_o  out  PW  player whose turn it is.
REQ-015 pairs_o  out  NUM_PLAYERS*CNT_W  packed pair counts, player p at [p*CNT_W +: CNT_W].
REQ-016 time_left_o  out  TW  remaining turn ticks.
REQ-017 show_winner_o  out  1  high only in GAME_OVER.
REQ-018 winner_o  out  PW  lowest-numbered player holding max pairs; valid with show_winner_o.
REQ-019 tie_o  out  1  high in GAME_OVER when >=2 players share max.

Function
REQ-020 States: IDLE, PICK1, PICK2, REVEAL, GAME_OVER; encoding internal.
REQ-021 IDLE/GAME_OVER + start_i -> PICK1 next cycle; clears faceup, removed, all pairs; player=0; timer=TICKS_PER_TURN-1.
REQ-022 start_i in PICK1/PICK2/REVEAL is ignored.
REQ-023 Valid click: click_i=1, sel_idx_i<NUM_CARDS, card not removed, not face-up; all other clicks ignored with no state change.
REQ-024 PICK1 valid click: faceup bit set next cycle, index stored, -> PICK2.
REQ-025 PICK2 valid click: faceup bit set next cycle, -> REVEAL, reveal counter=REVEAL_TICKS-1.
REQ-026 Timer decrements by 1 per cycle in PICK1/PICK2 only; holds in REVEAL.
REQ-027 Timeout: timer==0 in PICK1/PICK2 -> faceup cleared, player advances, timer reloaded, -> PICK1; timeout beats a same-cycle click (click discarded).
REQ-028 REVEAL ends on cycle with reveal counter==0; on next edge symbols compared.
REQ-029 Match: both bits moved faceup->removed, current player pairs +1, same player keeps turn, timer reloaded, -> PICK1.
REQ-030 Mismatch: faceup cleared, player=(player+1) mod NUM_PLAYERS, timer reloaded, -> PICK1.
REQ-031 If a match makes removed all ones, -> GAME_OVER on that edge instead of PICK1; winner_o/tie_o registered same edge.
REQ-032 Pair counters cannot overflow (max NUM_CARDS/2 fits CNT_W).
REQ-033 time_left_o reads timer value; reads TICKS_PER_TURN-1 in REVEAL after reload rule applies only on transition out.

Reset
REQ-034 rst wins over every input in the same cycle, including mid-REVEAL.
REQ-035 After reset: state IDLE; faceup_o, removed_o, pairs_o, current_player_o, show_winner_o, winner_o, tie_o all 0; time_left_o=TICKS_PER_TURN-1.

Configuration
REQ-036 Macro MEMGAME_TURN_TIMER_EN defined: turn timer and timeout per REQ-026/027 implemented.
REQ-037 Macro undefined: no timeout ever occurs, timer logic absent, time_left_o tied to 0; all other behaviour identical.

Verification (NUM_CARDS=16, NUM_PLAYERS=2, TICKS_PER_TURN=20, REVEAL_TICKS=3, layout symbol k=k>>1, macro defined unless stated)
REQ-038 Reset then start, click 0, click 1 -> after REVEAL removed_o=0x0003, pairs P0=1, current_player_o=0.
REQ-039 Click 0, click 2 -> faceup_o=0x0005 for 3 cycles, then 0x0000, current_player_o=1, pairs unchanged.
REQ-040 Click 0 then click 0 again or click removed card -> second click ignored, state stays PICK2, faceup_o=0x0001.
REQ-041 No clicks 20 cycles after PICK1 entry -> current_player_o advances to 1, time_left_o=19; click coincident with timer 0 discarded.
REQ-042 All 8 pairs by P0 -> show_winner_o=1, winner_o=0, tie_o=0; 4/4 split -> tie_o=1, winner_o=0; start_i then clears all.
REQ-043 rst asserted mid-REVEAL -> next cycle all outputs at REQ-035 values; macro undefined build: 100 idle cycles cause no turn change.

Source files
------------

// File: rtl/memory_game_core_np.sv
// Memory/concentration card-game controller for 2..4 players with pair scoring and winner detection.
// Optional per-turn timeout timer is built only when MEMGAME_TURN_TIMER_EN is defined.
module memory_game_core_np #(
    parameter int NUM_CARDS      = 16,
    parameter int NUM_PLAYERS    = 2,
    parameter int TICKS_PER_TURN = 750000000,
    parameter int REVEAL_TICKS   = 50000000,
    localparam int IDX_W = $clog2(NUM_CARDS),
    localparam int SYM_W = ($clog2(NUM_CARDS / 2) < 1) ? 1 : $clog2(NUM_CARDS / 2),
    localparam int PW    = $clog2(NUM_PLAYERS),
    localparam int CNT_W = $clog2(NUM_CARDS / 2 + 1),
    localparam int TW    = $clog2(TICKS_PER_TURN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         click_i,
    input  logic [IDX_W-1:0]             sel_idx_i,
    input  logic [NUM_CARDS*SYM_W-1:0]   layout_i,
    output logic [NUM_CARDS-1:0]         faceup_o,
    output logic [NUM_CARDS-1:0]         removed_o,
    output logic [PW-1:0]                current_player_o,
    output logic [NUM_PLAYERS*CNT_W-1:0] pairs_o,
    output logic [TW-1:0]                time_left_o,
    output logic                         show_winner_o,
    output logic [PW-1:0]                winner_o,
    output logic                         tie_o
);

    localparam int RW = ($clog2(REVEAL_TICKS) < 1) ? 1 : $clog2(REVEAL_TICKS);
    localparam logic [RW-1:0] REVEAL_LOAD = RW'(REVEAL_TICKS - 1);
    localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK1  = 3'd1,
        ST_PICK2  = 3'd2,
        ST_REVEAL = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    state_t                     state_q;
    logic [NUM_CARDS-1:0]       faceup_q;
    logic [NUM_CARDS-1:0]       removed_q;
    logic [IDX_W-1:0]           first_q;
    logic [IDX_W-1:0]           second_q;
    logic [PW-1:0]              player_q;
    logic [NUM_PLAYERS*CNT_W-1:0] pairs_q;
    logic [RW-1:0]              reveal_q;
    logic                       show_q;
    logic [PW-1:0]              winner_q;
    logic                       tie_q;

    logic [NUM_CARDS-1:0]       sel_hit_s;
    logic                       valid_click_s;
    logic                       timeout_s;
    logic [SYM_W-1:0]           sym_a_s;
    logic [SYM_W-1:0]           sym_b_s;
    logic                       match_s;
    logic                       board_done_s;
    logic [PW-1:0]              next_player_s;
    logic [NUM_PLAYERS*CNT_W-1:0] pairs_inc_s;
    logic [CNT_W-1:0]           best_cnt_s;
    logic [CNT_W-1:0]           cur_cnt_s;
    logic [PW-1:0]              best_p_s;
    logic                       tie_s;

    // Decode the clicked index and look up the symbols of both picked cards.
    always_comb begin
        sel_hit_s = '0;
        sym_a_s   = '0;
        sym_b_s   = '0;
        for (int k = 0; k < NUM_CARDS; k++) begin
            sel_hit_s[k] = (sel_idx_i == IDX_W'(k));
            sym_a_s = sym_a_s | ((first_q  == IDX_W'(k)) ? layout_i[k*SYM_W +: SYM_W] : SYM_W'(0));
            sym_b_s = sym_b_s | ((second_q == IDX_W'(k)) ? layout_i[k*SYM_W +: SYM_W] : SYM_W'(0));
        end
    end

    // An out-of-range index hits no card, so it is rejected along with face-up/removed cards.
    assign valid_click_s = click_i && (|sel_hit_s) && !(|(sel_hit_s & (faceup_q | removed_q)));
    assign match_s       = (sym_a_s == sym_b_s);
    assign board_done_s  = &(removed_q | faceup_q);
    assign next_player_s = (player_q == LAST_PLAYER) ? PW'(0) : (player_q + PW'(1));

    // Score table as it will be after a match, and the winner/tie verdict on that table.
    always_comb begin
        pairs_inc_s = '0;
        cur_cnt_s   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pairs_inc_s[p*CNT_W +: CNT_W] = pairs_q[p*CNT_W +: CNT_W] +
                ((player_q == PW'(p)) ? CNT_W'(1) : CNT_W'(0));
        end
        best_cnt_s = pairs_inc_s[CNT_W-1:0];
        best_p_s   = '0;
        tie_s      = 1'b0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            cur_cnt_s  = pairs_inc_s[p*CNT_W +: CNT_W];
            tie_s      = (cur_cnt_s > best_cnt_s) ? 1'b0 : (tie_s | (cur_cnt_s == best_cnt_s));
            best_p_s   = (cur_cnt_s > best_cnt_s) ? PW'(p) : best_p_s;
            best_cnt_s = (cur_cnt_s > best_cnt_s) ? cur_cnt_s : best_cnt_s;
        end
    end

`ifdef MEMGAME_TURN_TIMER_EN
    localparam logic [TW-1:0] TURN_LOAD = TW'(TICKS_PER_TURN - 1);
    logic [TW-1:0] timer_q;

    assign timeout_s = ((state_q == ST_PICK1) || (state_q == ST_PICK2)) && (timer_q == TW'(0));

    // Turn timer: runs only while picking, reloads at every turn boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= TURN_LOAD;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_i) begin
                        timer_q <= TURN_LOAD;
                    end
                end
                ST_PICK1, ST_PICK2: begin
                    if (timer_q == TW'(0)) begin
                        timer_q <= TURN_LOAD;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_REVEAL: begin
                    if (reveal_q == RW'(0)) begin
                        timer_q <= TURN_LOAD;
                    end
                end
                default: timer_q <= TURN_LOAD;
            endcase
        end
    end

    assign time_left_o = timer_q;
`else
    assign timeout_s   = 1'b0;
    assign time_left_o = '0;
`endif

    // Game state machine with all board, score and winner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            faceup_q  <= '0;
            removed_q <= '0;
            first_q   <= '0;
            second_q  <= '0;
            player_q  <= '0;
            pairs_q   <= '0;
            reveal_q  <= '0;
            show_q    <= 1'b0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_i) begin
                        state_q   <= ST_PICK1;
                        faceup_q  <= '0;
                        removed_q <= '0;
                        pairs_q   <= '0;
                        player_q  <= '0;
                        show_q    <= 1'b0;
                        winner_q  <= '0;
                        tie_q     <= 1'b0;
                    end
                end
                ST_PICK1: begin
                    if (timeout_s) begin
                        faceup_q <= '0;
                        player_q <= next_player_s;
                    end else if (valid_click_s) begin
                        faceup_q <= faceup_q | sel_hit_s;
                        first_q  <= sel_idx_i;
                        state_q  <= ST_PICK2;
                    end
                end
                ST_PICK2: begin
                    if (timeout_s) begin
                        faceup_q <= '0;
                        player_q <= next_player_s;
                        state_q  <= ST_PICK1;
                    end else if (valid_click_s) begin
                        faceup_q <= faceup_q | sel_hit_s;
                        second_q <= sel_idx_i;
                        reveal_q <= REVEAL_LOAD;
                        state_q  <= ST_REVEAL;
                    end
                end
                ST_REVEAL: begin
                    if (reveal_q != RW'(0)) begin
                        reveal_q <= reveal_q - RW'(1);
                    end else if (match_s) begin
                        removed_q <= removed_q | faceup_q;
                        faceup_q  <= '0;
                        pairs_q   <= pairs_inc_s;
                        if (board_done_s) begin
                            state_q  <= ST_OVER;
                            show_q   <= 1'b1;
                            winner_q <= best_p_s;
                            tie_q    <= tie_s;
                        end else begin
                            state_q <= ST_PICK1;
                        end
                    end else begin
                        faceup_q <= '0;
                        player_q <= next_player_s;
                        state_q  <= ST_PICK1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign faceup_o         = faceup_q;
    assign removed_o        = removed_q;
    assign current_player_o = player_q;
    assign pairs_o          = pairs_q;
    assign show_winner_o    = show_q;
    assign winner_o         = winner_q;
    assign tie_o            = tie_q;

endmodule

// File: tb/tb_memory_game_core_np.sv
// Bench for memory_game_core_np: per-cycle comparison against a game-rule model,
// directed scenarios with literal expectations, then randomized play.
module tb_memory_game_core_np;

    localparam int NC = 16, NP = 2, TPT = 20, RVT = 3;
    localparam int IDX_W = 4, SYM_W = 3, PW = 1, CNT_W = 4, TW = 5;
`ifdef MEMGAME_TURN_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_PICK1 = 1, P_PICK2 = 2, P_REVEAL = 3, P_OVER = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start_i = 1'b0;
    logic                  click_i = 1'b0;
    logic [IDX_W-1:0]      sel_idx_i = '0;
    logic [NC*SYM_W-1:0]   layout_i;
    logic [NC-1:0]         faceup_o, removed_o;
    logic [PW-1:0]         current_player_o, winner_o;
    logic [NP*CNT_W-1:0]   pairs_o;
    logic [TW-1:0]         time_left_o;
    logic                  show_winner_o, tie_o;

    memory_game_core_np #(
        .NUM_CARDS(NC), .NUM_PLAYERS(NP), .TICKS_PER_TURN(TPT), .REVEAL_TICKS(RVT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .click_i(click_i), .sel_idx_i(sel_idx_i),
        .layout_i(layout_i), .faceup_o(faceup_o), .removed_o(removed_o),
        .current_player_o(current_player_o), .pairs_o(pairs_o), .time_left_o(time_left_o),
        .show_winner_o(show_winner_o), .winner_o(winner_o), .tie_o(tie_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_phase, m_a, m_b, m_player, m_left, m_rev, m_show, m_winner, m_tie;
    int m_pairs [NP];
    logic [NC-1:0] m_face, m_rem;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_face = '0; m_rem = '0; m_player = 0; m_left = TPT - 1;
        m_rev = 0; m_a = 0; m_b = 0; m_show = 0; m_winner = 0; m_tie = 0;
        for (int p = 0; p < NP; p++) m_pairs[p] = 0;
    endtask

    task automatic model_resolve();
        int maxv, cnt;
        if ((m_a >> 1) == (m_b >> 1)) begin
            m_rem = m_rem | m_face;
            m_face = '0;
            m_pairs[m_player] = m_pairs[m_player] + 1;
            m_left = TPT - 1;
            if (m_rem == {NC{1'b1}}) begin
                m_phase = P_OVER;
                m_show = 1;
                maxv = 0;
                for (int p = 0; p < NP; p++) if (m_pairs[p] > maxv) maxv = m_pairs[p];
                cnt = 0;
                m_winner = -1;
                for (int p = 0; p < NP; p++) begin
                    if (m_pairs[p] == maxv) begin
                        cnt++;
                        if (m_winner < 0) m_winner = p;
                    end
                end
                m_tie = (cnt >= 2) ? 1 : 0;
            end else begin
                m_phase = P_PICK1;
            end
        end else begin
            m_face = '0;
            m_player = (m_player + 1) % NP;
            m_left = TPT - 1;
            m_phase = P_PICK1;
        end
    endtask

    task automatic model_step(input bit st, input bit ck, input int idx, input bit rs);
        if (rs) begin
            model_reset();
        end else if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (st) begin
                model_reset();
                m_phase = P_PICK1;
            end
        end else if (m_phase == P_PICK1 || m_phase == P_PICK2) begin
            if (TIMER_EN && m_left == 0) begin
                m_face = '0;
                m_player = (m_player + 1) % NP;
                m_left = TPT - 1;
                m_phase = P_PICK1;
            end else begin
                if (TIMER_EN) m_left = m_left - 1;
                if (ck && idx >= 0 && idx < NC && !m_face[idx] && !m_rem[idx]) begin
                    m_face[idx] = 1'b1;
                    if (m_phase == P_PICK1) begin
                        m_a = idx; m_phase = P_PICK2;
                    end else begin
                        m_b = idx; m_phase = P_REVEAL; m_rev = 0;
                    end
                end
            end
        end else if (m_phase == P_REVEAL) begin
            if (m_rev < RVT - 1) m_rev++;
            else model_resolve();
        end
    endtask

    task automatic compare_all();
        logic [NP*CNT_W-1:0] ep;
        ep = '0;
        for (int p = 0; p < NP; p++) ep = ep | (8'(m_pairs[p]) << (p * CNT_W));
        check("faceup", faceup_o, m_face);
        check("removed", removed_o, m_rem);
        check("player", current_player_o, m_player);
        check("pairs", pairs_o, ep);
        check("time_left", time_left_o, TIMER_EN ? m_left : 0);
        check("show_winner", show_winner_o, m_show);
        check("winner", winner_o, m_winner);
        check("tie", tie_o, m_tie);
    endtask

    // Called at a falling edge: drive inputs, advance the model, cross one rising edge, compare.
    task automatic tick(input bit st, input bit ck, input int idx, input bit rs);
        rst = rs; start_i = st; click_i = ck; sel_idx_i = IDX_W'(idx);
        model_step(st, ck, idx, rs);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic click(input int idx);
        tick(1'b0, 1'b1, idx, 1'b0);
    endtask

    task automatic new_game();
        tick(1'b0, 1'b0, 0, 1'b1);
        tick(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic take_pair(input int p);
        click(2 * p); click(2 * p + 1); idle(RVT);
    endtask

    initial begin
        int ck_pct, idx, r;
        bit st, ck, rs;
        for (int k = 0; k < NC; k++) layout_i[k*SYM_W +: SYM_W] = 3'(k >> 1);
        model_reset();
        @(negedge clk);

        // Reset values
        tick(1'b1, 1'b1, 3, 1'b1);
        check("rst_faceup", faceup_o, 16'h0000);
        check("rst_pairs", pairs_o, 8'h00);
        check("rst_time", time_left_o, TIMER_EN ? 5'd19 : 5'd0);

        // First pair matched by player 0
        tick(1'b1, 1'b0, 0, 1'b0);
        click(0); click(1); idle(RVT);
        check("match_removed", removed_o, 16'h0003);
        check("match_pairs", pairs_o, 8'h01);
        check("match_player", current_player_o, 1'b0);

        // Mismatch shows both cards for the reveal window, then passes the turn
        new_game();
        click(0); click(2);
        check("mis_face0", faceup_o, 16'h0005);
        idle(1); check("mis_face1", faceup_o, 16'h0005);
        idle(1); check("mis_face2", faceup_o, 16'h0005);
        idle(1);
        check("mis_face_clr", faceup_o, 16'h0000);
        check("mis_player", current_player_o, 1'b1);
        check("mis_pairs", pairs_o, 8'h00);

        // Re-clicking the open card or a removed card is ignored
        click(0); click(0);
        check("dup_face", faceup_o, 16'h0001);
        click(1); idle(RVT);
        check("p1_pairs", pairs_o, 8'h10);
        click(0);
        check("removed_click", faceup_o, 16'h0000);

`ifdef MEMGAME_TURN_TIMER_EN
        // Timeout passes the turn; a click on the timeout cycle is discarded
        new_game();
        idle(TPT - 1);
        check("to_before_player", current_player_o, 1'b0);
        check("to_before_time", time_left_o, 5'd0);
        idle(1);
        check("to_player", current_player_o, 1'b1);
        check("to_time", time_left_o, 5'd19);
        idle(TPT - 1);
        click(5);
        check("to_click_face", faceup_o, 16'h0000);
        check("to_click_player", current_player_o, 1'b0);
`else
        new_game();
        idle(100);
        check("notimer_player", current_player_o, 1'b0);
        check("notimer_time", time_left_o, 5'd0);
`endif

        // Player 0 clears the board alone; start clears everything
        new_game();
        for (int p = 0; p < NC / 2; p++) take_pair(p);
        check("solo_show", show_winner_o, 1'b1);
        check("solo_winner", winner_o, 1'b0);
        check("solo_tie", tie_o, 1'b0);
        check("solo_pairs", pairs_o, 8'h08);
        tick(1'b1, 1'b0, 0, 1'b0);
        check("restart_show", show_winner_o, 1'b0);
        check("restart_removed", removed_o, 16'h0000);
        check("restart_pairs", pairs_o, 8'h00);

        // 4/4 split ends in a tie reported for player 0
        new_game();
        for (int p = 0; p < 4; p++) take_pair(p);
        click(8); click(10); idle(RVT);
        for (int p = 4; p < 8; p++) take_pair(p);
        check("tie_flag", tie_o, 1'b1);
        check("tie_winner", winner_o, 1'b0);
        check("tie_pairs", pairs_o, 8'h44);

        // Player 1 wins 5 to 3
        new_game();
        for (int p = 0; p < 3; p++) take_pair(p);
        click(6); click(8); idle(RVT);
        for (int p = 3; p < 8; p++) take_pair(p);
        check("p1win_winner", winner_o, 1'b1);
        check("p1win_tie", tie_o, 1'b0);
        check("p1win_pairs", pairs_o, 8'h53);

        // Reset in the middle of a reveal beats start and click
        new_game();
        click(0); click(2); idle(1);
        tick(1'b1, 1'b1, 3, 1'b1);
        check("midrst_face", faceup_o, 16'h0000);
        check("midrst_player", current_player_o, 1'b0);
        check("midrst_time", time_left_o, TIMER_EN ? 5'd19 : 5'd0);

        // Randomized play with alternating slow and fast click phases
        new_game();
        for (int c = 0; c < 6000; c++) begin
            ck_pct = ((c / 400) % 3 == 0) ? 4 : 55;
            r  = $urandom_range(0, 999);
            rs = (r < 2);
            st = (m_phase == P_IDLE || m_phase == P_OVER) ? ($urandom_range(0, 3) == 0)
                                                          : ($urandom_range(0, 49) == 0);
            ck = ($urandom_range(0, 99) < ck_pct);
            if (m_phase == P_PICK2 && $urandom_range(0, 1) == 1) idx = m_a ^ 1;
            else idx = $urandom_range(0, NC - 1);
            tick(st, ck, idx, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
